// File: rtl/clefia_gfn_round_ctrl.sv
// Round controller for the 4-branch CLEFIA GFN: whitening, NR rounds through the external F0/F1 stage, output handshake.
// Optional decryption support (dec port, reversed key order, right rotation) is enabled by defining CLEFIA_DEC_EN.
module clefia_gfn_round_ctrl #(
  parameter int NR    = 18,
  parameter int F_LAT = 3,
  parameter int RKW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CLEFIA_DEC_EN
  input  logic             dec,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  input  logic [127:0]     wk,
  output logic [RKW-1:0]   rk_idx,
  input  logic [63:0]      rk_pair,
  output logic             f_valid,
  output logic [31:0]      f0_x,
  output logic [31:0]      f1_x,
  output logic [31:0]      f0_k,
  output logic [31:0]      f1_k,
  input  logic [31:0]      f0_y,
  input  logic [31:0]      f1_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic             busy
);

  localparam int CW = (F_LAT > 1) ? $clog2(F_LAT) : 1;
  localparam logic [RKW-1:0] R_LAST = RKW'(NR - 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(F_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    t0_q, t1_q, t2_q, t3_q;
  logic [31:0]    t0_d, t1_d, t2_d, t3_d;
  logic [31:0]    wkf2_q, wkf3_q, wkf2_d, wkf3_d;
  logic [RKW-1:0] r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   out_block_q, out_block_d;
  logic           out_valid_q, out_valid_d;
  logic [31:0]    fx0_q, fx1_q, fk0_q, fk1_q;
  logic [31:0]    fx0_d, fx1_d, fk0_d, fk1_d;
  logic           dec_q, dec_d;
  logic           dec_acc;
  logic [31:0]    t1x, t3x;

`ifdef CLEFIA_DEC_EN
  assign dec_acc = dec;
`else
  assign dec_acc = 1'b0;
`endif

  assign t1x = t1_q ^ f0_y;
  assign t3x = t3_q ^ f1_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      t0_q        <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      t3_q        <= '0;
      wkf2_q      <= '0;
      wkf3_q      <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      out_block_q <= '0;
      out_valid_q <= 1'b0;
      fx0_q       <= '0;
      fx1_q       <= '0;
      fk0_q       <= '0;
      fk1_q       <= '0;
      dec_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      t3_q        <= t3_d;
      wkf2_q      <= wkf2_d;
      wkf3_q      <= wkf3_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      out_block_q <= out_block_d;
      out_valid_q <= out_valid_d;
      fx0_q       <= fx0_d;
      fx1_q       <= fx1_d;
      fk0_q       <= fk0_d;
      fk1_q       <= fk1_d;
      dec_q       <= dec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    t3_d        = t3_q;
    wkf2_d      = wkf2_q;
    wkf3_d      = wkf3_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    out_block_d = out_block_q;
    out_valid_d = out_valid_q;
    fx0_d       = fx0_q;
    fx1_d       = fx1_q;
    fk0_d       = fk0_q;
    fk1_d       = fk1_q;
    dec_d       = dec_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          t0_d  = in_block[127:96];
          t2_d  = in_block[63:32];
          dec_d = dec_acc;
          // Only the final-whitening key pair is kept; the input pair is consumed here.
          if (dec_acc) begin
            t1_d   = in_block[95:64] ^ wk[63:32];
            t3_d   = in_block[31:0]  ^ wk[31:0];
            wkf2_d = wk[127:96];
            wkf3_d = wk[95:64];
          end else begin
            t1_d   = in_block[95:64] ^ wk[127:96];
            t3_d   = in_block[31:0]  ^ wk[95:64];
            wkf2_d = wk[63:32];
            wkf3_d = wk[31:0];
          end
          r_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fx0_d   = t0_q;
        fx1_d   = t2_q;
        fk0_d   = rk_pair[63:32];
        fk1_d   = rk_pair[31:0];
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (r_q == R_LAST) begin
            out_block_d = {t0_q, t1x ^ wkf2_q, t2_q, t3x ^ wkf3_q};
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            if (dec_q) begin
              t0_d = t3x;
              t1_d = t0_q;
              t2_d = t1x;
              t3_d = t2_q;
            end else begin
              t0_d = t1x;
              t1_d = t2_q;
              t2_d = t3x;
              t3_d = t0_q;
            end
            r_d     = r_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // F operands are live during ISSUE and hold the issued values otherwise.
  assign f_valid   = (state_q == S_ISSUE);
  assign f0_x      = f_valid ? t0_q : fx0_q;
  assign f1_x      = f_valid ? t2_q : fx1_q;
  assign f0_k      = f_valid ? rk_pair[63:32] : fk0_q;
  assign f1_k      = f_valid ? rk_pair[31:0]  : fk1_q;
  assign rk_idx    = dec_q ? (R_LAST - r_q) : r_q;
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;

endmodule
